// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the multi-channel DAC frame serializer.
//   DEF_DATA_W    default bits per channel sample
//   DEF_NUM_CH    default channels per frame
//   DEF_SCLK_HALF default system clocks per SCLK half-period
//   sample_t      one signed sample at the default width
//   cnt_width()   width of a counter that must hold 0..n-1 (never less than 1)
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_SCLK_HALF = 32;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

    // A count range of a single value still needs a one-bit register.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dac_frame_serializer_if.sv
// -----------------------------------------------------------------------------
// dac_frame_serializer_if
// Valid/ready frame handshake between the sample source and the serializer.
//   s_valid  source has a frame on s_data
//   s_ready  serializer holding register is empty
//   s_data   NUM_CH samples, channel c at s_data[c*DATA_W +: DATA_W]
// Modports: master (sample source), slave (serializer).
// -----------------------------------------------------------------------------
interface dac_frame_serializer_if
    import dac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH
) ();

    logic                     s_valid;
    logic                     s_ready;
    logic [NUM_CH*DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/dac_sclk_gen.sv
// -----------------------------------------------------------------------------
// dac_sclk_gen
// Divides the system clock down to the DAC serial clock.
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   sclk_o     out  serial clock, low out of reset
//   rise_tick  out  high in the clk cycle just before sclk_o goes high
//   fall_tick  out  high in the clk cycle just before sclk_o goes low
// SCLK_HALF system clocks make one SCLK half-period.
// -----------------------------------------------------------------------------
module dac_sclk_gen
    import dac_pkg::*;
#(
    parameter int SCLK_HALF = DEF_SCLK_HALF
) (
    input  logic clk,
    input  logic reset_n,
    output logic sclk_o,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int              CNT_W = cnt_width(SCLK_HALF);
    localparam logic [CNT_W-1:0] TC   = CNT_W'(SCLK_HALF - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             terminal;

    assign terminal  = (div_cnt == TC);
    assign rise_tick = terminal && !sclk_o;
    assign fall_tick = terminal && sclk_o;

    // The divider restarts from zero whenever the serial clock toggles, so
    // each SCLK level lasts exactly SCLK_HALF system clocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            sclk_o  <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            sclk_o  <= ~sclk_o;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_frame_serializer.sv
// -----------------------------------------------------------------------------
// dac_frame_serializer
// Accepts frames of NUM_CH signed samples over a valid/ready handshake, holds
// one frame in a holding register and shifts whole frames out MSB-first,
// channel 0 first, with word and frame strobes for the DAC.
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   s_bus       slave frame handshake (s_valid, s_ready, s_data)
//   sclk_o      out  serial clock
//   sdata_o     out  serial data, updated on SCLK falling edges
//   ws_o        out  high for the SCLK period carrying each word MSB
//   fs_o        out  high for the SCLK period carrying channel 0 MSB
//   underrun_o  out  one-clk pulse when a frame boundary finds no frame held
//   mute_i      in   only with DAC_SERIALIZER_MUTE_EN defined: send zeros at
//                    the next frame boundary and discard any held frame
// -----------------------------------------------------------------------------
module dac_frame_serializer
    import dac_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int SCLK_HALF = DEF_SCLK_HALF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dac_frame_serializer_if.slave  s_bus,
    output logic                   sclk_o,
    output logic                   sdata_o,
    output logic                   ws_o,
    output logic                   fs_o,
    output logic                   underrun_o
`ifdef DAC_SERIALIZER_MUTE_EN
    ,
    input  logic                   mute_i
`endif
);

    localparam int               FRAME_W  = NUM_CH * DATA_W;
    localparam int               BIT_W    = cnt_width(DATA_W);
    localparam int               CH_W     = cnt_width(NUM_CH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    logic               rise_tick;
    logic               fall_tick;
    logic               hold_full;
    logic [FRAME_W-1:0] hold_data;
    logic [FRAME_W-1:0] hold_reordered;
    logic [FRAME_W-1:0] shift_reg;
    logic [FRAME_W-1:0] next_shift;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CH_W-1:0]    ch_cnt;
    logic               accept;
    logic               word_end;
    logic               boundary;
    logic               mute_now;

    dac_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .sclk_o    (sclk_o),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Everything here moves on falling SCLK edges; rise_tick only serves as a
    // sanity check that the two tick strobes never coincide.
    always_comb begin
        assert (!(rise_tick && fall_tick));
    end

`ifdef DAC_SERIALIZER_MUTE_EN
    assign mute_now = mute_i;
`else
    assign mute_now = 1'b0;
`endif

    assign s_bus.s_ready = !hold_full;
    assign accept        = s_bus.s_valid && !hold_full;
    assign word_end      = (bit_cnt == BIT_LAST);
    assign boundary      = fall_tick && word_end && (ch_cnt == CH_LAST);

    // The bus carries channel 0 in the low bits, but the shifter sends its
    // MSB first, so channel 0 must land in the top slice of the shift word.
    always_comb begin
        hold_reordered = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hold_reordered[(NUM_CH-1-c)*DATA_W +: DATA_W] = hold_data[c*DATA_W +: DATA_W];
        end
    end

    // At a frame boundary the shifter reloads from the holding register, or
    // with silence when nothing is held or the output is muted; otherwise it
    // just advances one bit.
    always_comb begin
        next_shift = '0;
        if (boundary) begin
            if (hold_full && !mute_now) begin
                next_shift = hold_reordered;
            end
        end else begin
            next_shift = shift_reg << 1;
        end
    end

    // Holding register, shifter, counters and all serial outputs. An accept
    // can only happen while the holding register is empty, so it never races
    // a boundary load of the same frame: a frame accepted on a boundary cycle
    // waits for the next boundary and that boundary underruns. sdata_o takes
    // the new MSB directly from next_shift so it changes together with ws_o
    // and fs_o on the falling SCLK edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full  <= 1'b0;
            hold_data  <= '0;
            shift_reg  <= '0;
            bit_cnt    <= BIT_LAST;
            ch_cnt     <= CH_LAST;
            sdata_o    <= 1'b0;
            ws_o       <= 1'b0;
            fs_o       <= 1'b0;
            underrun_o <= 1'b0;
        end else begin
            underrun_o <= 1'b0;

            if (accept) begin
                hold_full <= 1'b1;
                hold_data <= s_bus.s_data;
            end else if (boundary) begin
                hold_full <= 1'b0;
            end

            if (fall_tick) begin
                shift_reg <= next_shift;
                sdata_o   <= next_shift[FRAME_W-1];
                if (boundary) begin
                    bit_cnt    <= '0;
                    ch_cnt     <= '0;
                    ws_o       <= 1'b1;
                    fs_o       <= 1'b1;
                    underrun_o <= !hold_full && !mute_now;
                end else if (word_end) begin
                    bit_cnt <= '0;
                    ch_cnt  <= ch_cnt + 1'b1;
                    ws_o    <= 1'b1;
                    fs_o    <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    ws_o    <= 1'b0;
                    fs_o    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_dac_frame_serializer.sv
// -----------------------------------------------------------------------------
// tb_dac_frame_serializer
// Self-checking bench for dac_frame_serializer. A 2x16-bit instance with
// SCLK_HALF=2 carries the frame-level checks; a 4x24-bit instance with
// SCLK_HALF=3 checks the strobe spacing. The mute checks are built only when
// DAC_SERIALIZER_MUTE_EN is defined.
// -----------------------------------------------------------------------------
module tb_dac_frame_serializer;
    import dac_pkg::*;

    localparam int DATA_W        = 16;
    localparam int NUM_CH        = 2;
    localparam int SCLK_HALF     = 2;
    localparam int BIG_DATA_W    = 24;
    localparam int BIG_NUM_CH    = 4;
    localparam int BIG_SCLK_HALF = 3;

    localparam logic [31:0] EXP_WS = 32'h8000_8000;
    localparam logic [31:0] EXP_FS = 32'h8000_0000;

    typedef struct {
        bit          offer;
        sample_t     ch0;
        sample_t     ch1;
        logic [31:0] expSerial;
        int          expUnderrun;
    } vec_t;

    logic clk;
    logic reset_n;
    logic sclk_o, sdata_o, ws_o, fs_o, underrun_o;
    logic big_sclk, big_sdata, big_ws, big_fs, big_underrun;
`ifdef DAC_SERIALIZER_MUTE_EN
    logic mute_i;
`endif

    int          vecCount;
    int          missCount;
    int          urnSeen;
    logic [31:0] pend[$];

    dac_frame_serializer_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) s_bus ();
    dac_frame_serializer_if #(.DATA_W(BIG_DATA_W), .NUM_CH(BIG_NUM_CH)) big_bus ();

    dac_frame_serializer #(
        .DATA_W    (DATA_W),
        .NUM_CH    (NUM_CH),
        .SCLK_HALF (SCLK_HALF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_bus      (s_bus),
        .sclk_o     (sclk_o),
        .sdata_o    (sdata_o),
        .ws_o       (ws_o),
        .fs_o       (fs_o),
        .underrun_o (underrun_o)
`ifdef DAC_SERIALIZER_MUTE_EN
        ,
        .mute_i     (mute_i)
`endif
    );

    dac_frame_serializer #(
        .DATA_W    (BIG_DATA_W),
        .NUM_CH    (BIG_NUM_CH),
        .SCLK_HALF (BIG_SCLK_HALF)
    ) big_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_bus      (big_bus),
        .sclk_o     (big_sclk),
        .sdata_o    (big_sdata),
        .ws_o       (big_ws),
        .fs_o       (big_fs),
        .underrun_o (big_underrun)
`ifdef DAC_SERIALIZER_MUTE_EN
        ,
        .mute_i     (1'b0)
`endif
    );

    // Free-running 10-unit system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: count it, and report it if the DUT disagrees.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Queue a frame for the source driver; it goes on the bus at once if idle.
    task automatic applyStimulus(input sample_t ch0, input sample_t ch1);
        pend.push_back({ch1, ch0});
        if (s_bus.s_valid !== 1'b1) begin
            s_bus.s_valid = 1'b1;
            s_bus.s_data  = pend[0];
        end
    endtask

    // Advance one system clock, acting as the valid/ready source and counting
    // underrun pulses. Idle data is garbage that must never be captured.
    task automatic tick();
        logic        hs;
        logic [31:0] dropped;
        hs = s_bus.s_valid && s_bus.s_ready;
        @(posedge clk);
        #1;
        if (hs && pend.size() > 0) begin
            dropped = pend.pop_front();
        end
        if (pend.size() > 0) begin
            s_bus.s_valid = 1'b1;
            s_bus.s_data  = pend[0];
        end else begin
            s_bus.s_valid = 1'b0;
            s_bus.s_data  = 32'hDEAD_BEEF;
        end
        if (underrun_o === 1'b1) begin
            urnSeen++;
        end
    endtask

    // Collect nbits serial bits starting at a frame boundary; bit b lands in
    // position 31-b. pre ticks of the first bit have already been spent.
    task automatic runFrame(input int pre, input int nbits, output logic [31:0] sd,
                            output logic [31:0] ws, output logic [31:0] fs, output int urn);
        sd      = '0;
        ws      = '0;
        fs      = '0;
        urnSeen = 0;
        for (int b = 0; b < nbits; b++) begin
            repeat ((b == 0) ? 4 - pre : 4) tick();
            sd[31-b] = sdata_o;
            ws[31-b] = ws_o;
            fs[31-b] = fs_o;
        end
        urn = urnSeen;
    endtask

    task automatic checkFrame(input string name, input logic [31:0] sd, input logic [31:0] ws,
                              input logic [31:0] fs, input int urn,
                              input logic [31:0] expSd, input int expUrn);
        checkOutput({name, "_sdata"}, sd, expSd);
        checkOutput({name, "_ws"}, ws, EXP_WS);
        checkOutput({name, "_fs"}, fs, EXP_FS);
        checkOutput({name, "_underruns"}, 32'(urn), 32'(expUrn));
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_sclk"}, {31'b0, sclk_o}, 32'd0);
        checkOutput({name, "_sdata"}, {31'b0, sdata_o}, 32'd0);
        checkOutput({name, "_ws"}, {31'b0, ws_o}, 32'd0);
        checkOutput({name, "_fs"}, {31'b0, fs_o}, 32'd0);
        checkOutput({name, "_underrun"}, {31'b0, underrun_o}, 32'd0);
        checkOutput({name, "_s_ready"}, {31'b0, s_bus.s_ready}, 32'd1);
    endtask

    // After reset release the first boundary must arrive on the 4th clock:
    // nothing on the 3rd, then an underrun frame of zeros.
    task automatic checkStartup(input string name);
        logic [31:0] sd, ws, fs;
        int          urn;
        urnSeen = 0;
        repeat (3) tick();
        checkOutput({name, "_early_ws"}, {31'b0, ws_o}, 32'd0);
        checkOutput({name, "_early_underrun"}, 32'(urnSeen), 32'd0);
        runFrame(3, 32, sd, ws, fs, urn);
        checkFrame(name, sd, ws, fs, urn, 32'h0000_0000, 1);
    endtask

    // Main sequence.
    initial begin
        vec_t        vecs[5];
        logic [31:0] sd, ws, fs;
        int          urn;
        int          cyc;
        int          fsT[$];
        int          wsT[$];
        logic        pf, pw;

        vecs[0] = '{1'b1, 16'h8001, 16'h7FFE, 32'h8001_7FFE, 0};
        vecs[1] = '{1'b0, 16'h0000, 16'h0000, 32'h0000_0000, 1};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h0000, 32'hFFFF_0000, 0};
        vecs[3] = '{1'b1, 16'h0000, 16'hFFFF, 32'h0000_FFFF, 0};
        vecs[4] = '{1'b1, 16'hA5A5, 16'h5A5A, 32'hA5A5_5A5A, 0};

        vecCount        = 0;
        missCount       = 0;
        urnSeen         = 0;
        reset_n         = 1'b0;
        s_bus.s_valid   = 1'b0;
        s_bus.s_data    = 32'hDEAD_BEEF;
        big_bus.s_valid = 1'b0;
        big_bus.s_data  = '0;
`ifdef DAC_SERIALIZER_MUTE_EN
        mute_i          = 1'b0;
`endif

        $display("[TB] reset and first boundary");
        repeat (3) tick();
        checkResetState("reset");
        reset_n = 1'b1;
        checkStartup("frame0");

        $display("[TB] frame table");
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].offer) begin
                applyStimulus(vecs[i].ch0, vecs[i].ch1);
            end
            runFrame(0, 32, sd, ws, fs, urn);
            checkFrame($sformatf("vec%0d", i), sd, ws, fs, urn, vecs[i].expSerial, vecs[i].expUnderrun);
        end

        $display("[TB] back-to-back frames");
        applyStimulus(16'h1234, 16'h5678);
        applyStimulus(16'hABCD, 16'hEF01);
        tick();
        checkOutput("b2b_second_waits", {31'b0, s_bus.s_ready}, 32'd0);
        runFrame(1, 32, sd, ws, fs, urn);
        checkFrame("b2b_a", sd, ws, fs, urn, 32'h1234_5678, 0);
        runFrame(0, 32, sd, ws, fs, urn);
        checkFrame("b2b_b", sd, ws, fs, urn, 32'hABCD_EF01, 0);

        $display("[TB] reset in mid-frame");
        applyStimulus(16'hC3C3, 16'h3D3C);
        applyStimulus(16'h1111, 16'h2222);
        tick();
        runFrame(1, 24, sd, ws, fs, urn);
        checkOutput("midreset_partial", sd, 32'hC3C3_3D00);
        repeat (2) tick();
        checkOutput("midreset_pre_sclk", {31'b0, sclk_o}, 32'd1);
        checkOutput("midreset_pre_sdata", {31'b0, sdata_o}, 32'd1);
        checkOutput("midreset_pre_hold", {31'b0, s_bus.s_ready}, 32'd0);
        pend.delete();
        s_bus.s_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        checkResetState("midreset");
        repeat (2) tick();
        reset_n = 1'b1;
        checkStartup("restart");

`ifdef DAC_SERIALIZER_MUTE_EN
        $display("[TB] mute");
        mute_i = 1'b1;
        applyStimulus(16'hFFFF, 16'hFFFF);
        tick();
        checkOutput("mute_hold_full", {31'b0, s_bus.s_ready}, 32'd0);
        runFrame(1, 32, sd, ws, fs, urn);
        checkFrame("mute", sd, ws, fs, urn, 32'h0000_0000, 0);
        checkOutput("mute_ready_after", {31'b0, s_bus.s_ready}, 32'd1);
        mute_i = 1'b0;
        runFrame(0, 32, sd, ws, fs, urn);
        checkFrame("unmute_discarded", sd, ws, fs, urn, 32'h0000_0000, 1);
`endif

        $display("[TB] 4x24 strobe spacing");
        cyc = 0;
        pf  = big_fs;
        pw  = big_ws;
        while (cyc < 2000 && fsT.size() < 2) begin
            @(posedge clk);
            #1;
            cyc++;
            if (big_fs === 1'b1 && pf !== 1'b1) begin
                fsT.push_back(cyc);
            end
            if (big_ws === 1'b1 && pw !== 1'b1 && fsT.size() >= 1) begin
                wsT.push_back(cyc);
            end
            pf = big_fs;
            pw = big_ws;
        end
        checkOutput("big_fs_found", 32'(fsT.size()), 32'd2);
        checkOutput("big_fs_period", (fsT.size() >= 2) ? 32'(fsT[1] - fsT[0]) : 32'd0, 32'd576);
        checkOutput("big_ws_period", (wsT.size() >= 2) ? 32'(wsT[1] - wsT[0]) : 32'd0, 32'd144);
        checkOutput("big_words_per_frame", (wsT.size() >= 1) ? 32'(wsT.size() - 1) : 32'd0, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
